// File: rtl/masked_xor_ctrl_pkg.sv
// Shared types and constants for the masked XOR controller and its DOM stages.
package masked_pkg;

    localparam int RAND_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        S1,
        S2,
        OUT
    } state_t;

    // One value split into two shares: value = s0 ^ s1.
    typedef struct packed {
        logic s0;
        logic s1;
    } share_t;

    // Complementing a shared value only needs one share inverted.
    function automatic share_t share_not(input share_t x);
        share_t r;
        r.s0 = ~x.s0;
        r.s1 = x.s1;
        return r;
    endfunction

endpackage

// File: rtl/masked_xor_ctrl_if.sv
// Operand, randomness and result handshakes of the masked XOR controller.
interface masked_xor_ctrl_if;
    import masked_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              a0;
    logic              a1;
    logic              b0;
    logic              b1;
    logic              rnd_req;
    logic              rnd_valid;
    logic [RAND_W-1:0] rnd_data;
    logic              out_valid;
    logic              out_ready;
    logic              y0;
    logic              y1;

    // Controller side.
    modport slave (
        input  in_valid, a0, a1, b0, b1, rnd_valid, rnd_data, out_ready,
        output in_ready, rnd_req, out_valid, y0, y1
    );

    // Producer/consumer side.
    modport master (
        output in_valid, a0, a1, b0, b1, rnd_valid, rnd_data, out_ready,
        input  in_ready, rnd_req, out_valid, y0, y1
    );

endinterface

// File: rtl/masked_xor_ctrl_dom_and.sv
// One registered DOM AND layer: z = x & y over two shares, refreshed by r.
module dom_and_stage
    import masked_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en_i,
    input  logic   clr_i,
    input  share_t x_i,
    input  share_t y_i,
    input  logic   r_i,
    output share_t z_o
);

    share_t z_d;
    share_t z_q;

    // Each domain combines its own product with the remasked cross product.
    always_comb begin
        z_d.s0 = (x_i.s0 & y_i.s0) ^ ((x_i.s0 & y_i.s1) ^ r_i);
        z_d.s1 = (x_i.s1 & y_i.s1) ^ ((x_i.s1 & y_i.s0) ^ r_i);
    end

    // Output register isolates this layer from the next; clear wins over load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= '0;
        end else if (clr_i) begin
            // NOTE: non-blocking assignment so every register samples pre-edge values.
            z_q <= '0;
        end else if (en_i) begin
            z_q <= z_d;
        end
    end

    assign z_o = z_q;

endmodule

// File: rtl/masked_xor_ctrl.sv
// Sequencing controller for a 2-share first-order masked XOR built from DOM AND layers.
module masked_xor_ctrl
    import masked_pkg::*;
#(
    parameter int STARVE_LIM = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    masked_xor_ctrl_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic             rnd_starve
);

    localparam int                WAIT_W = $clog2(STARVE_LIM + 1);
    localparam logic [WAIT_W-1:0] LIM_W  = WAIT_W'(STARVE_LIM);

    state_t            state_q, state_d;
    share_t            a_q, a_d;
    share_t            b_q, b_d;
    logic [RAND_W-1:0] rnd_q, rnd_d;
    share_t            y_q, y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              starve_q, starve_d;

    share_t path1, path2, and12;
    logic   in_ready;
    logic   accept;
    logic   rnd_fire;
    logic   out_hs;

    assign accept   = bus.in_valid & in_ready;
    assign rnd_fire = (state_q == FETCH) & bus.rnd_valid;
    assign out_hs   = (state_q == OUT) & bus.out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = FETCH;
                FETCH:   if (bus.rnd_valid) state_d = S1;
                S1:      state_d = S2;
                S2:      state_d = OUT;
                OUT:     if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        in_ready      = (state_q == IDLE) & ~rst;
        bus.rnd_req   = (state_q == FETCH);
        bus.out_valid = (state_q == OUT);
        busy          = (state_q != IDLE);
    end

    assign bus.in_ready = in_ready;

    // First layer: ~A & B with r0 and A & ~B with r1, captured in S1, wiped once used in S2.
    dom_and_stage u_path1 (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == S1),
        .clr_i (abort | (state_q == S2)),
        .x_i   (share_not(a_q)),
        .y_i   (b_q),
        .r_i   (rnd_q[0]),
        .z_o   (path1)
    );

    dom_and_stage u_path2 (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == S1),
        .clr_i (abort | (state_q == S2)),
        .x_i   (a_q),
        .y_i   (share_not(b_q)),
        .r_i   (rnd_q[1]),
        .z_o   (path2)
    );

    // Second layer: path1 & path2 with r2, captured in S2, held until the output handshake.
    dom_and_stage u_and12 (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == S2),
        .clr_i (abort | out_hs),
        .x_i   (path1),
        .y_i   (path2),
        .r_i   (rnd_q[2]),
        .z_o   (and12)
    );

    // Next values of operand, randomness, result-share and counter registers.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        rnd_d    = rnd_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        wait_d   = '0;
        starve_d = starve_q;

        if (abort || state_q == S2) begin
            a_d   = '0;
            b_d   = '0;
            rnd_d = '0;
        end else begin
            if (accept) begin
                a_d = '{s0: bus.a0, s1: bus.a1};
                b_d = '{s0: bus.b0, s1: bus.b1};
            end
            if (rnd_fire) rnd_d = bus.rnd_data;
        end

        // Per-domain partial sums; the and12 share is folded in at the output.
        if (abort || out_hs) begin
            y_d = '0;
        end else if (state_q == S2) begin
            y_d.s0 = path1.s0 ^ path2.s0;
            y_d.s1 = path1.s1 ^ path2.s1;
        end

        if (out_hs && !abort) cnt_d = cnt_q + 1'b1;

        // Wait counter only lives while stalled in FETCH; it saturates at the limit.
        if (!abort && state_q == FETCH && !bus.rnd_valid) begin
            wait_d = (wait_q == LIM_W) ? wait_q : wait_q + 1'b1;
        end
        if (wait_d == LIM_W) starve_d = 1'b1;
    end

    // Datapath and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            rnd_q    <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            rnd_q    <= rnd_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end

    // Each output share only mixes registered values of its own domain.
    assign bus.y0     = y_q.s0 ^ and12.s0;
    assign bus.y1     = y_q.s1 ^ and12.s1;
    assign op_count   = cnt_q;
    assign rnd_starve = starve_q;

endmodule

// File: tb/tb_masked_xor_ctrl.sv
// Scoreboard bench for masked_xor_ctrl: stimulus pushes A^B, a monitor pops on each output handshake.
module tb_masked_xor_ctrl;

    logic       clk;
    logic       rst;
    logic       abort;
    logic       busy;
    logic [7:0] op_count;
    logic       rnd_starve;

    masked_xor_ctrl_if bus ();

    masked_xor_ctrl #(
        .STARVE_LIM (16),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .op_count   (op_count),
        .rnd_starve (rnd_starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    bit sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the recombined result whenever an output handshake is pending.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    check("y0^y1", int'(bus.y0 ^ bus.y1), int'(sb.pop_front()));
                end
            end
        end
    end

    // One transaction: sh = {a0,a1,b0,b1}; stall FETCH cycles without rnd_valid;
    // hold cycles of out_ready low; abort_at = cycle to abort (0 = none);
    // rst_at_out = assert rst while the result is presented.
    task automatic do_op(input logic [3:0] sh, input int stall, input int hold,
                         input int abort_at, input bit rst_at_out,
                         output int lat, output int reqs, output int used, output int starve_n);
        int   n;
        logic hy0, hy1;
        lat = 0; reqs = 0; used = 0; starve_n = 0;

        @(negedge clk);
        check("in_ready_idle", int'(bus.in_ready), 1);
        {bus.a0, bus.a1, bus.b0, bus.b1} = sh;
        bus.in_valid  = 1'b1;
        bus.rnd_valid = (stall == 0);
        bus.rnd_data  = 3'($urandom);
        bus.out_ready = (hold == 0) && !rst_at_out;
        sb.push_back((sh[3] ^ sh[2]) ^ (sh[1] ^ sh[0]));
        @(posedge clk);

        n = 0;
        while (lat == 0) begin
            @(negedge clk);
            n++;
            bus.in_valid = 1'b0;
            {bus.a0, bus.a1, bus.b0, bus.b1} = 4'b0000;
            bus.rnd_valid = (n > stall);
            bus.rnd_data  = 3'($urandom);
            if (bus.rnd_req) begin
                reqs++;
                if (bus.rnd_valid) used++;
            end
            if (rnd_starve && starve_n == 0) starve_n = n;
            if (n == abort_at) begin
                abort = 1'b1;
                bus.out_ready = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                void'(sb.pop_back());
                check("abort_busy", int'(busy), 0);
                check("abort_cnt", int'(op_count), exp_cnt % 256);
                for (int k = 0; k < 4; k++) begin
                    check("abort_no_out_valid", int'(bus.out_valid), 0);
                    @(negedge clk);
                end
                return;
            end
            if (bus.out_valid) begin
                lat = n;
            end else if (n >= 200) begin
                check("out_valid_timeout", n, -1);
                void'(sb.pop_back());
                return;
            end
        end

        if (rst_at_out) begin
            #3;
            rst = 1'b1;
            #1;
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_y0", int'(bus.y0), 0);
            check("rst_y1", int'(bus.y1), 0);
            check("rst_op_count", int'(op_count), 0);
            check("rst_starve", int'(rnd_starve), 0);
            check("rst_in_ready", int'(bus.in_ready), 0);
            sb.delete();
            exp_cnt = 0;
            @(negedge clk);
            rst = 1'b0;
            bus.out_ready = 1'b1;
            return;
        end

        hy0 = bus.y0;
        hy1 = bus.y1;
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            check("hold_y0", int'(bus.y0), int'(hy0));
            check("hold_y1", int'(bus.y1), int'(hy1));
            check("hold_in_ready", int'(bus.in_ready), 0);
            check("hold_out_valid", int'(bus.out_valid), 1);
        end
        check("op_count_pre", int'(op_count), exp_cnt % 256);
        bus.out_ready = 1'b1;
        @(posedge clk);
        exp_cnt++;
        #1;
        check("op_count_post", int'(op_count), exp_cnt % 256);
        check("out_valid_drop", int'(bus.out_valid), 0);
        check("y_cleared", int'({bus.y0, bus.y1}), 0);
    endtask

    int lat, reqs, used, starve_n;

    initial begin
        rst           = 1'b1;
        abort         = 1'b0;
        bus.in_valid  = 1'b0;
        {bus.a0, bus.a1, bus.b0, bus.b1} = 4'b0000;
        bus.rnd_valid = 1'b0;
        bus.rnd_data  = 3'b000;
        bus.out_ready = 1'b1;

        // Reset state.
        #13;
        check("reset_in_ready", int'(bus.in_ready), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_rnd_req", int'(bus.rnd_req), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_op_count", int'(op_count), 0);
        check("reset_starve", int'(rnd_starve), 0);
        @(negedge clk);
        rst = 1'b0;

        // Output backpressure on the first operation: op_count 0 -> 1.
        do_op(4'b1011, 0, 3, 0, 1'b0, lat, reqs, used, starve_n);
        check("bp_latency", lat, 4);

        // All 16 share encodings with randomness always available.
        for (int i = 0; i < 16; i++) begin
            do_op(4'(i), 0, 0, 0, 1'b0, lat, reqs, used, starve_n);
            check("basic_latency", lat, 4);
            check("basic_rnd_req", reqs, 1);
            check("basic_words", used, 1);
        end

        // Five-cycle randomness stall.
        do_op(4'b0110, 5, 0, 0, 1'b0, lat, reqs, used, starve_n);
        check("stall_latency", lat, 9);
        check("stall_rnd_req", reqs, 6);
        check("stall_words", used, 1);
        check("stall_no_starve", starve_n, 0);

        // Starvation: 20 stalled FETCH cycles, flag seen after 16 of them.
        do_op(4'b1001, 20, 0, 0, 1'b0, lat, reqs, used, starve_n);
        check("starve_rise_cycle", starve_n, 17);
        check("starve_latency", lat, 24);
        check("starve_sticky", int'(rnd_starve), 1);

        // Abort in S2, then a clean operation with a new word.
        do_op(4'b1100, 0, 0, 3, 1'b0, lat, reqs, used, starve_n);
        do_op(4'b1110, 0, 0, 0, 1'b0, lat, reqs, used, starve_n);
        check("post_abort_latency", lat, 4);
        check("post_abort_words", used, 1);

        // Async reset while presenting a result, then normal operation.
        do_op(4'b0111, 0, 0, 0, 1'b1, lat, reqs, used, starve_n);
        do_op(4'b0001, 0, 0, 0, 1'b0, lat, reqs, used, starve_n);
        check("post_rst_latency", lat, 4);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/masked_xor_ctrl.md
# masked_xor_ctrl

Sequencing controller for a 2-share, first-order masked XOR datapath built from domain-oriented (DOM) AND layers. It accepts one share-encoded operand pair per transaction and fetches exactly one fresh 3-bit randomness word per operation over a request/valid handshake. It then steps the gadget through two register-isolated stages so no glitch path combines shares of the same domain. It returns the output share pair over a valid/ready handshake.

## Interface
- STARVE_LIM, 16: consecutive FETCH cycles without rnd_valid before rnd_starve sets.
- CNT_W, 8: width of op_count.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous flush; returns to IDLE from any state.
- in_valid  in  1  operand shares valid.
- in_ready  out  1  accept; high only in IDLE and only while rst is low.
- a0, a1, b0, b1  in  1 each  operand shares, with A = a0^a1 and B = b0^b1.
- rnd_req  out  1  randomness request; high only in FETCH.
- rnd_valid  in  1  randomness word valid.
- rnd_data  in  3  fresh random bits {r2,r1,r0}.
- out_valid  out  1  result shares valid.
- out_ready  in  1  consumer accept.
- y0, y1  out  1 each  result shares, with y0^y1 = A^B.
- busy  out  1  state is not IDLE.
- op_count  out  CNT_W  completed operations; wraps modulo 2^CNT_W.
- rnd_starve  out  1  sticky starvation flag.

## Operation
- FSM states: IDLE → FETCH → S1 → S2 → OUT → IDLE.
- **IDLE:** when in_valid and in_ready are both high, register a0..b1 and go to FETCH.
- **FETCH:** drive rnd_req=1.
  - When rnd_valid=1, latch rnd_data and go to S1.
  - Otherwise stay in FETCH. The controller never proceeds without a fresh word.
  - rnd_valid outside FETCH is ignored and no word is consumed.
- **S1:** compute the two first-layer DOM ANDs and register them.
  - path1 = ~A & B, using r0.
  - path2 = A & ~B, using r1.
  - Domain i output = own-domain product ^ cross-domain product ^ r.
- **S2:** compute and12 = path1 & path2 as a DOM AND using r2, then y_i = path1_i ^ path2_i ^ and12_i, and register y0/y1.
  - Clear the randomness register to 0 in the same cycle.
- **OUT:** out_valid=1, with y0/y1 held stable until out_ready.
  - On the handshake: op_count += 1, y0/y1 clear to 0, go to IDLE.
- **Share hygiene:** the operand registers clear to 0 on the S2→OUT transition. No register ever holds a recombined (unmasked) value.
- **rnd_starve:** a wait counter increments each FETCH cycle without rnd_valid and resets on leaving FETCH. When it reaches STARVE_LIM, rnd_starve sets and stays set until rst.
- **abort:** has priority over every transition.
  - Next state is IDLE.
  - All share, random and y registers clear to 0 and out_valid drops.
  - op_count does not increment, even if out_ready is high in the same cycle.
  - rnd_starve is unaffected.
- **Reset values:** state=IDLE, out_valid=0, rnd_req=0, busy=0, y0=y1=0, op_count=0, rnd_starve=0, all internal registers 0. in_ready is 0 while rst is asserted.

## Timing
- Accept at edge t.
- FETCH during t+1.
  - If rnd_valid is high in that cycle, S1 is at t+2, S2 at t+3, and out_valid first goes high at t+4.
  - Each FETCH cycle without rnd_valid adds one cycle.
- Minimum accept-to-out_valid latency is 4 cycles.
- No overlap between operations, so peak throughput is one operation per 5 cycles: in_ready returns the cycle after the out handshake.
- rnd_req and rnd_valid high in the same cycle means the word is consumed at that edge.
- The counters are registered. op_count is visible the cycle after the handshake.
- rst asserted mid-operation forces immediate reset values; no output glitch back to a previous value after release.

## Structure
- Package masked_pkg contains:
  - state enum {IDLE, FETCH, S1, S2, OUT};
  - RAND_W = 3;
  - a share-pair struct {s0, s1}.
- Sub-module dom_and_stage:
  - Inputs: two share pairs and one random bit.
  - Output: one share pair, registered on clk/rst, with a load enable and a synchronous clear.
  - Instantiated three times: two in S1, one in S2.
- The final y_i XOR and the y register live in the top level.

## Test plan
- **Basic:** all 16 combinations of (A,B) across share splits, with rnd_valid held high → out_valid at t+4 and y0^y1 = A^B every time (e.g. a0=1,a1=0,b0=1,b1=1 → y0^y1=1).
- **Randomness stall:** rnd_valid withheld for 5 FETCH cycles → out_valid at t+9. rnd_req is high exactly 6 cycles, and exactly one word is consumed.
- **Starvation:** STARVE_LIM=16 with rnd_valid held low for 20 cycles → rnd_starve rises after 16 FETCH cycles and stays high after the operation completes.
- **Output backpressure:** out_ready low for 3 cycles → y0/y1 stable throughout, and in_ready stays 0. On the handshake op_count goes 0→1; the next accept is 1 cycle later.
- **Abort:** abort asserted in S2 → IDLE next cycle, out_valid never rises, op_count unchanged. The following operation is correct and consumes a new word.
- **Async reset:** rst asserted during OUT with out_valid=1 → out_valid, y0, y1, op_count and rnd_starve all drop to 0 without waiting for a clock edge. Normal operation resumes after release.
